// File: rtl/dpwm_if.sv
// Control/status bundle between the voltage-loop compensator and the DPWM.
// master drives run control and duty command; slave is the modulator.
interface dpwm_if;
   logic       enable;
   logic [9:0] d_in;
   logic       hs_gate;
   logic       ls_gate;
   logic       period_start;
   logic       sample_strobe;
   logic [9:0] duty_active;
   logic       clamp_hit;

   modport master (
      output enable, d_in,
      input  hs_gate, ls_gate, period_start, sample_strobe, duty_active, clamp_hit
   );

   modport slave (
      input  enable, d_in,
      output hs_gate, ls_gate, period_start, sample_strobe, duty_active, clamp_hit
   );
endinterface

// File: rtl/dpwm.sv
// Fixed 1024-cycle DPWM: latches a clamped duty at period wrap and drives
// complementary gates with dead-time plus period/ADC sample strobes.
module dpwm #(
   parameter int DEAD_TIME = 4,
   parameter int D_MIN     = 0,
   parameter int D_MAX     = 1000,
   parameter int SAMPLE_PT = 512
) (
   input  logic   clk,
   input  logic   rst,
   dpwm_if.slave  bus
);

   localparam logic [10:0] T11    = 11'(DEAD_TIME);
   localparam logic [10:0] LS_END = 11'(1024 - DEAD_TIME);
   localparam logic [9:0]  DMIN10 = 10'(D_MIN);
   localparam logic [9:0]  DMAX10 = 10'(D_MAX);
   localparam logic [10:0] DMIN11 = {1'b0, DMIN10};
   localparam logic [10:0] DMAX11 = {1'b0, DMAX10};
   localparam logic [9:0]  SPT    = 10'(SAMPLE_PT);

   logic [9:0]  cnt_q, cnt_d;
   logic [9:0]  duty_q, duty_d;
   logic        clamp_q, clamp_d;
   logic        hs_q, hs_d, ls_q, ls_d, ps_q, ps_d, ss_q, ss_d;
   logic [10:0] c11, dq11, din11;
   logic        wrap, below, above;

   always_comb begin
      // 11-bit compares so duty + dead-time never wraps
      c11   = {1'b0, cnt_q};
      dq11  = {1'b0, duty_q};
      din11 = {1'b0, bus.d_in};
      wrap  = (cnt_q == 10'd1023);
      below = (din11 + 11'd1) <= DMIN11;
      above = din11 > DMAX11;

      cnt_d   = cnt_q;
      duty_d  = duty_q;
      clamp_d = clamp_q;
      hs_d    = 1'b0;
      ls_d    = 1'b0;
      ps_d    = 1'b0;
      ss_d    = 1'b0;

      if (!bus.enable) begin
         cnt_d = 10'd1023;
      end else begin
         cnt_d = wrap ? 10'd0 : cnt_q + 10'd1;
         if (wrap) begin
            duty_d  = below ? DMIN10 : (above ? DMAX10 : bus.d_in);
            clamp_d = below | above;
         end
         hs_d = (c11 < dq11);
         ls_d = (c11 >= dq11 + T11) && (c11 < LS_END);
         ps_d = (cnt_q == 10'd0);
         ss_d = (cnt_q == SPT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 10'd1023;
         duty_q  <= 10'd0;
         clamp_q <= 1'b0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         ps_q    <= 1'b0;
         ss_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         clamp_q <= clamp_d;
         hs_q    <= hs_d;
         ls_q    <= ls_d;
         ps_q    <= ps_d;
         ss_q    <= ss_d;
      end
   end

   assign bus.hs_gate       = hs_q;
   assign bus.ls_gate       = ls_q;
   assign bus.period_start  = ps_q;
   assign bus.sample_strobe = ss_q;
   assign bus.duty_active   = duty_q;
   assign bus.clamp_hit     = clamp_q;

endmodule

// File: tb/tb_dpwm.sv
// Directed bench for dpwm: per-period gate/strobe profiles, duty latch timing,
// clamping, enable drop/restore and mid-period reset.
module tb_dpwm;

   logic clk = 1'b0;
   logic rst;
   int   npass = 0;
   int   ntot  = 0;

   dpwm_if bus ();

   dpwm #(.DEAD_TIME(4), .D_MIN(0), .D_MAX(1000), .SAMPLE_PT(512)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // per-period profile, filled by meas()
   int m_hs, m_hs_first, m_hs_last, m_ls, m_ls_first, m_ls_last;
   int m_ss, m_ss_off, m_both, m_ps_extra, m_duty_pre, m_duty_end, m_clamp_end;

   task automatic chk(input string tag, input int obs, input int exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Call at a negedge where period_start is high; index i equals the decoded
   // counter value. Optionally changes d_in at index chg_at. Ends at the next
   // period's first negedge.
   task automatic meas(input int chg_at, input logic [9:0] chg_val);
      m_hs = 0; m_hs_first = -1; m_hs_last = -1;
      m_ls = 0; m_ls_first = -1; m_ls_last = -1;
      m_ss = 0; m_ss_off = -1; m_both = 0; m_ps_extra = 0;
      m_duty_pre = -1; m_duty_end = -1; m_clamp_end = -1;
      for (int i = 0; i < 1024; i++) begin
         if (i == chg_at) bus.d_in = chg_val;
         if (bus.hs_gate) begin
            if (m_hs_first < 0) m_hs_first = i;
            m_hs_last = i;
            m_hs++;
         end
         if (bus.ls_gate) begin
            if (m_ls_first < 0) m_ls_first = i;
            m_ls_last = i;
            m_ls++;
         end
         if (bus.sample_strobe) begin
            m_ss++;
            m_ss_off = i;
         end
         if (bus.hs_gate && bus.ls_gate) m_both++;
         if (bus.period_start && i != 0) m_ps_extra++;
         if (i == 1022) m_duty_pre = int'(bus.duty_active);
         if (i == 1023) begin
            m_duty_end  = int'(bus.duty_active);
            m_clamp_end = int'(bus.clamp_hit);
         end
         @(negedge clk);
      end
   endtask

   task automatic chk_gates(input string tag, input int hs_w, input int ls_first, input int ls_w);
      chk({tag, "_hs_w"}, m_hs, hs_w);
      chk({tag, "_hs_first"}, m_hs_first, (hs_w > 0) ? 0 : -1);
      chk({tag, "_hs_last"}, m_hs_last, hs_w - 1);
      chk({tag, "_ls_first"}, m_ls_first, ls_first);
      chk({tag, "_ls_last"}, m_ls_last, 1019);
      chk({tag, "_ls_w"}, m_ls, ls_w);
      chk({tag, "_overlap"}, m_both, 0);
      chk({tag, "_ss_off"}, m_ss_off, 512);
      chk({tag, "_ss_n"}, m_ss, 1);
      chk({tag, "_ps_extra"}, m_ps_extra, 0);
      chk({tag, "_ps_next"}, int'(bus.period_start), 1);
   endtask

   initial begin
      int acts;
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.d_in = 10'd0;
      repeat (3) @(negedge clk);
      chk("rst_hs", int'(bus.hs_gate), 0);
      chk("rst_ls", int'(bus.ls_gate), 0);
      chk("rst_ps", int'(bus.period_start), 0);
      chk("rst_ss", int'(bus.sample_strobe), 0);
      chk("rst_duty", int'(bus.duty_active), 0);
      chk("rst_clamp", int'(bus.clamp_hit), 0);

      // start-up with duty 300: latch on first edge, period_start on second
      rst = 1'b0;
      bus.enable = 1'b1;
      bus.d_in = 10'd300;
      @(negedge clk);
      chk("start_ps0", int'(bus.period_start), 0);
      chk("start_hs0", int'(bus.hs_gate), 0);
      chk("start_duty", int'(bus.duty_active), 300);
      @(negedge clk);
      chk("start_ps1", int'(bus.period_start), 1);
      chk("start_hs1", int'(bus.hs_gate), 1);
      meas(-1, 10'd0);
      chk_gates("p300", 300, 304, 716);

      // change to 500 mid-period: current width held, new one one period later
      meas(100, 10'd500);
      chk("chg_hs_w", m_hs, 300);
      chk("chg_duty_pre", m_duty_pre, 300);
      chk("chg_duty_end", m_duty_end, 500);
      meas(10, 10'd1023);
      chk_gates("p500", 500, 504, 516);
      chk("clamp_duty_end", m_duty_end, 1000);
      chk("clamp_hit_end", m_clamp_end, 1);

      meas(10, 10'd200);
      chk_gates("p1000", 1000, 1004, 16);
      chk("unclamp_duty", m_duty_end, 200);
      chk("unclamp_hit", m_clamp_end, 0);

      meas(10, 10'd0);
      chk_gates("p200", 200, 204, 816);
      meas(10, 10'd300);
      chk_gates("p0", 0, 4, 1016);
      chk("p0_clamp", m_clamp_end, 0);
      chk("p0_duty_end", m_duty_end, 300);

      // drop enable at c=150
      repeat (150) @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("dis_hs", int'(bus.hs_gate), 0);
      chk("dis_ls", int'(bus.ls_gate), 0);
      chk("dis_duty", int'(bus.duty_active), 300);
      bus.d_in = 10'd600;
      acts = 0;
      for (int i = 0; i < 1200; i++) begin
         if (bus.hs_gate || bus.ls_gate || bus.period_start || bus.sample_strobe) acts++;
         @(negedge clk);
      end
      chk("dis_quiet", acts, 0);
      chk("dis_duty_hold", int'(bus.duty_active), 300);

      // re-enable with 600
      bus.enable = 1'b1;
      @(negedge clk);
      chk("reen_ps0", int'(bus.period_start), 0);
      chk("reen_hs0", int'(bus.hs_gate), 0);
      chk("reen_duty", int'(bus.duty_active), 600);
      @(negedge clk);
      chk("reen_ps1", int'(bus.period_start), 1);
      meas(-1, 10'd0);
      chk_gates("p600", 600, 604, 416);

      // synchronous reset at c=700 with enable held high
      repeat (700) @(negedge clk);
      bus.d_in = 10'd250;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_hs", int'(bus.hs_gate), 0);
      chk("mrst_ls", int'(bus.ls_gate), 0);
      chk("mrst_ss", int'(bus.sample_strobe), 0);
      chk("mrst_duty", int'(bus.duty_active), 0);
      @(negedge clk);
      chk("mrst_ps0", int'(bus.period_start), 0);
      chk("mrst_duty_latch", int'(bus.duty_active), 250);
      @(negedge clk);
      chk("mrst_ps1", int'(bus.period_start), 1);
      meas(-1, 10'd0);
      chk_gates("p250", 250, 254, 766);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/dpwm.md
# dpwm

Digital PWM generator that sits directly downstream of the SMPS voltage-loop compensator. It consumes the compensator's 10-bit duty command, latches it once per switching period, and drives complementary high-side/low-side gate signals with fixed dead-time. It also emits the period-start and ADC sample strobes that pace the upstream sense/compensate chain. The switching period is fixed at 1024 clk cycles.

## Interface
- DEAD_TIME, 4: cycles with both gates low around every gate transition; legal range 1..63.
- D_MIN, 0: lower clamp applied to the latched duty.
- D_MAX, 1000: upper clamp applied to the latched duty; must satisfy D_MIN <= D_MAX <= 1024 - 2*DEAD_TIME.
- SAMPLE_PT, 512: counter value (0..1023) at which sample_strobe fires.
- clk  input  1  system clock; all logic is single-clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run control; low parks the modulator with both gates off.
- d_in  input  10  unsigned duty command (compensator d_out), sampled only at period wrap.
- hs_gate  output  1  high-side gate drive, registered.
- ls_gate  output  1  low-side gate drive, registered.
- period_start  output  1  one-cycle pulse, first cycle of each period.
- sample_strobe  output  1  one-cycle pulse at counter value SAMPLE_PT; drives the ADC/compensator enable.
- duty_active  output  10  duty currently in force (post-clamp).
- clamp_hit  output  1  high while duty_active came from a clamped d_in.

## Operation
- Registers: cnt (10 bit), duty_active, clamp_hit, plus the four registered decode outputs.
- Reset (edge with rst=1, overrides enable): cnt <= 1023; duty_active <= 0; clamp_hit <= 0; hs_gate, ls_gate, period_start, sample_strobe <= 0.
- Edge with enable=1: cnt <= (cnt==1023) ? 0 : cnt+1. Count wraps from 1023 to 0.
- Duty latch: on the edge where cnt==1023 and enable=1, duty_active <= clamp(d_in) and clamp_hit <= (d_in < D_MIN or d_in > D_MAX). d_in is ignored at all other times.
- Decode (c = current cnt, D = duty_active, T = DEAD_TIME; all compares on 11-bit unsigned so D+T cannot wrap):
  - hs_gate <= (c < D)
  - ls_gate <= (c >= D+T) and (c < 1024-T)
  - period_start <= (c == 0)
  - sample_strobe <= (c == SAMPLE_PT)
- The parameter constraint guarantees hs_gate and ls_gate are never both high, with at least T low-low cycles between them at each edge.
- D = 0: hs_gate never asserts; ls_gate is high for c in T..1023-T.
- Edge with enable=0: cnt <= 1023; hs_gate, ls_gate, period_start, sample_strobe <= 0; duty_active and clamp_hit hold.
- Re-enable: the first enabled edge sees cnt==1023, so it wraps, latches fresh d_in, and drives gates low (the decode of 1023 is always off). The period then restarts cleanly.

## Timing
- Decoded outputs lag cnt by one cycle: period_start is high in the cycle after cnt reads 0.
- A new duty takes effect on the first cycle where period_start=1.
- duty_active and clamp_hit change one cycle before that period_start pulse.
- d_in-to-gate latency: d_in is sampled at the cnt==1023 edge; hs_gate reflects it 2 edges later (coincident with period_start).
- enable 1->0: gates are low after the next edge; there is no completion of the current period.
- enable 0->1 at edge E0: period_start and hs_gate (if D>0) assert after edge E1.
- rst asserted mid-period: outputs are 0 after that edge regardless of enable.
- Outputs do not glitch; all are flop outputs.

## Test plan
- Parameters are defaults for all scenarios (T=4, D_MIN=0, D_MAX=1000, SAMPLE_PT=512).
- Reset, then enable with d_in=300: period_start every 1024 cycles; hs_gate high 300 cycles starting with period_start; ls_gate high for c=304..1019 (716 cycles); sample_strobe 512 cycles after period_start; gates never both high.
- d_in 300->500 at c=100: the current period keeps hs width 300; the next period has hs width 500 and duty_active=500 one cycle before its period_start.
- d_in=1023: duty_active=1000, clamp_hit=1; hs width 1000; ls high for c=1004..1019 (16 cycles). Then d_in=200: clamp_hit drops at the next latch.
- d_in=0: hs_gate stays 0; ls_gate high for c=4..1019; clamp_hit=0.
- Drop enable at c=150 with d_in=300: both gates 0 after the next edge, strobes stop, duty_active holds 300. Re-enable with d_in=600: the first period_start comes 2 edges later and hs width is 600.
- rst pulse at c=700 while enabled: all outputs 0 and duty_active=0 after the edge. With enable still high, the next edge wraps and latches d_in, and normal periods resume.
